sigdel_adc_decim: RTL and testbench
===================================

Name: sigdel_adc_decim

Overview:
- Receive-side counterpart of the team's first-order sigma-delta DAC.
- Accepts a 1-bit pulse-density bitstream, e.g. from a comparator/latch front end or a DAC loopback.
- Recovers BITLEN-bit unsigned samples with a 2nd-order CIC (sinc^2) decimator.
- Results go out on a valid/ready interface with a sticky overrun flag.
- Scaling matches the DAC: a ones-density of V/2^BITLEN decodes to V.

Parameters:
- BITLEN, 16: output sample width; same meaning as the DAC input width.
- DECIM_LOG2, 6: log2 of the decimation ratio (DECIM = 64); legal range 2..12.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- in_en  input  1  bit-rate enable; in_bit is sampled only when in_en=1.
- in_bit  input  1  sigma-delta bitstream bit; 1 counts as +1, 0 counts as 0.
- out_data  output  BITLEN  decoded unsigned sample.
- out_valid  output  1  out_data holds an unconsumed sample.
- out_ready  input  1  consumer accepts a sample when out_valid && out_ready.
- ovr_clr  input  1  synchronous clear of overrun.
- overrun  output  1  sticky: a sample was overwritten before it was accepted.

Behaviour:
- Reset (async, rst=1): all internal state and every output go to 0 (out_data, out_valid, overrun).
- Reset mid-operation: any in-flight pipeline samples are discarded. Counting restarts at the first in_en after rst deasserts.
- Internal width W = 2*DECIM_LOG2+1, unsigned, modulo 2^W.
  - CIC wrap-around is intentional; no saturation inside the filter.
- Integrators, updated only on in_en=1:
  - i1 <= i1 + in_bit
  - i2 <= i2 + i1, using the old i1
  - With in_en=0, i1 and i2 hold.
- Decimation counter cnt (DECIM_LOG2 bits):
  - increments on in_en;
  - on the in_en cycle with cnt=DECIM-1 it wraps to 0 and asserts tick on the next cycle (T+1).
- Comb pipeline, one stage per cycle, runs regardless of in_en:
  - T+1 (tick): c1 <= i2 - d1; d1 <= i2.
  - T+2: c2 <= c1 - d2; d2 <= c1.
  - T+3: out_data <= scale(c2); out_valid <= 1.
  - Latency from the wrapping in_en cycle to out_valid = 3 clk.
- scale(r), with r in 0..2^(2*DECIM_LOG2):
  - If r = 2^(2*DECIM_LOG2), saturate to all ones.
  - Else if 2*DECIM_LOG2 >= BITLEN, r >> (2*DECIM_LOG2-BITLEN).
  - Else r << (BITLEN-2*DECIM_LOG2).
- Settling: the first 2 outputs after reset are filter transient. From the 3rd output on, a constant-density input gives the exact value.
- Handshake:
  - out_valid && out_ready with no new sample: out_valid <= 0 next cycle.
  - New sample and acceptance in the same cycle: load the new sample, out_valid stays 1, no overrun.
  - New sample while out_valid=1 && out_ready=0: overwrite out_data, out_valid stays 1, overrun <= 1.
  - out_data is stable while out_valid=1 && out_ready=0, except on overwrite.
- overrun:
  - cleared by ovr_clr=1.
  - Simultaneous ovr_clr and a new overrun event: overrun = 1 (set wins).
- in_en may be high every cycle (bit rate = clk) or sparse; the output cadence is DECIM in_en pulses per sample.

Decomposition:
- Package sigdel_pkg holds:
  - function cic_width(DECIM_LOG2) returning W;
  - the scale() function;
  - shared constant DEFAULT_BITLEN = 16, also to be reused by the DAC.
- One sub-module, sigdel_cic_integrator (width W, enable, async active-high reset, acc <= acc + in):
  - instantiated twice;
  - first instance has a 1-bit zero-extended input, second has a W-bit input.
- Counter, combs, scaling and output register live in the top module.

Test Plan:
- All-ones: in_en=1 every cycle, in_bit=1, out_ready=1, defaults.
  - 3rd and later outputs = 0xFFFF (saturated 4096); one out_valid pulse every 64 clk.
- All-zeros: same setup with in_bit=0.
  - Every output = 0x0000; overrun stays 0.
- Alternating 1,0:
  - 3rd and later outputs = 0x8000 (2048 << 4).
- Loopback: DAC (BITLEN=16) driven with 0x4000 feeding in_bit, in_en=1.
  - Outputs settle to 0x4000 ±0x0010.
- Backpressure: out_ready=0 across two output events.
  - First sample held stable; second overwrites it; overrun=1 at T+3 of the second event.
  - ovr_clr pulse -> overrun=0.
  - Accept-and-new in the same cycle -> out_valid stays 1, overrun stays 0.
- Async reset mid-window: assert rst for half a clk period at cnt=30, out_valid=1.
  - out_valid, out_data and overrun = 0 immediately, before the next clk edge.
  - Next valid arrives 64 in_en pulses + 3 clk after rst deasserts.

Source files
------------

// File: rtl/sigdel_pkg.sv
// Shared constants and helpers for the sigma-delta DAC/ADC pair.
// The CIC sizing and output scaling live here so both ends agree on the number format.
package sigdel_pkg;

  localparam int DEFAULT_BITLEN = 16;

  // A sinc^2 filter over 2^dlog2 samples grows 2*dlog2 bits; one extra bit holds full scale.
  function automatic int cic_width(input int dlog2);
    return 2 * dlog2 + 1;
  endfunction

  // Map a CIC result r in 0..2^(2*dlog2) onto a bitlen-bit unsigned code.
  // Full scale (all ones in) is the only value that cannot be represented, so it clamps.
  // The result is returned in 32 bits, so bitlen is limited to 32.
  function automatic logic [31:0] scale(input logic [31:0] r, input int dlog2, input int bitlen);
    int          rw;
    logic [31:0] res;
    rw = 2 * dlog2;
    if (r == (32'd1 << rw)) begin
      res = (bitlen >= 32) ? '1 : ((32'd1 << bitlen) - 32'd1);
    end else if (rw >= bitlen) begin
      res = r >> (rw - bitlen);
    end else begin
      res = r << (bitlen - rw);
    end
    return res;
  endfunction

endpackage

// File: rtl/sigdel_cic_integrator.sv
// One CIC integrator stage: a free-running modulo-2^W accumulator gated by a bit-rate enable.
module sigdel_cic_integrator
  import sigdel_pkg::*;
#(
  parameter int W = 13
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] acc
);

  // Wrap-around is part of the CIC arithmetic; the combs undo it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     acc <= '0;
    else if (en) acc <= acc + din;
  end

endmodule

// File: rtl/sigdel_adc_decim.sv
// Sigma-delta bitstream decoder: two integrators at bit rate, decimate by 2^DECIM_LOG2,
// two combs at clock rate, scale to BITLEN bits, valid/ready output with sticky overrun.
module sigdel_adc_decim
  import sigdel_pkg::*;
#(
  parameter int BITLEN     = DEFAULT_BITLEN,
  parameter int DECIM_LOG2 = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_en,
  input  logic              in_bit,
  output logic [BITLEN-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              ovr_clr,
  output logic              overrun
);

  localparam int W = cic_width(DECIM_LOG2);
  localparam logic [DECIM_LOG2-1:0] CNT_MAX = '1;

  logic [W-1:0]            i1, i2;
  logic [W-1:0]            d1, d2, c1, c2;
  logic [DECIM_LOG2-1:0]   cnt;
  logic                    wrap;
  // [0] tick (c1 load), [1] c2 load, [2] output load
  logic [2:0]              vld_pipe;

  assign wrap = in_en && (cnt == CNT_MAX);

  sigdel_cic_integrator #(.W(W)) u_int1 (
    .clk (clk),
    .rst (rst),
    .en  (in_en),
    .din ({{(W-1){1'b0}}, in_bit}),
    .acc (i1)
  );

  // Fed from the registered i1, so each update uses the pre-update first integrator.
  sigdel_cic_integrator #(.W(W)) u_int2 (
    .clk (clk),
    .rst (rst),
    .en  (in_en),
    .din (i1),
    .acc (i2)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      vld_pipe <= '0;
    end else begin
      if (in_en) cnt <= cnt + 1'b1;
      vld_pipe <= {vld_pipe[1:0], wrap};
    end
  end

  // Comb stages advance on the clock, not on in_en, so latency is fixed in clk cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c1 <= '0;
      d1 <= '0;
      c2 <= '0;
      d2 <= '0;
    end else begin
      if (vld_pipe[0]) begin
        c1 <= i2 - d1;
        d1 <= i2;
      end
      if (vld_pipe[1]) begin
        c2 <= c1 - d2;
        d2 <= c1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (vld_pipe[2]) begin
        out_data  <= BITLEN'(scale(32'(c2), DECIM_LOG2, BITLEN));
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      // A fresh overwrite takes priority over a clear in the same cycle.
      if (vld_pipe[2] && out_valid && !out_ready) overrun <= 1'b1;
      else if (ovr_clr)                           overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sigdel_adc_decim.sv
// Bench for sigdel_adc_decim: randomized and directed bitstreams against a sinc^2 kernel model.
module tb_sigdel_adc_decim;

  localparam int DECIM = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_en = 1'b0;
  logic        in_bit = 1'b0;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        ovr_clr = 1'b0;
  logic        overrun;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bit          hist[$];
  int          due_q[$];
  int          due_k[$];
  logic [15:0] samples[$];
  int          vcyc[$];
  bit          exp_valid;
  bit          exp_ovr;
  logic [15:0] exp_data;

  sigdel_adc_decim #(.BITLEN(16), .DECIM_LOG2(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_en     (in_en),
    .in_bit    (in_bit),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ovr_clr   (ovr_clr),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Number of times bit j is summed into the second integrator after n bits.
  function automatic longint tri_w(input int n, input int j);
    return (n - 1 - j > 0) ? longint'(n - 1 - j) : 64'sd0;
  endfunction

  // Sample k (1-based) as a triangular-kernel convolution of the recorded bitstream.
  function automatic logic [15:0] model(input int k);
    longint r = 0;
    longint v;
    for (int j = (k - 2) * DECIM; j < k * DECIM; j++) begin
      if (j >= 0 && j < int'(hist.size()) && hist[j])
        r += tri_w(k * DECIM, j) - 2 * tri_w((k - 1) * DECIM, j) + tri_w((k - 2) * DECIM, j);
    end
    v = r * 16;
    if (v > 65535) v = 65535;
    return 16'(v);
  endfunction

  task automatic clear_model();
    hist.delete();
    due_q.delete();
    due_k.delete();
    samples.delete();
    vcyc.delete();
    exp_valid = 0;
    exp_ovr   = 0;
    exp_data  = '0;
  endtask

  // One clock with the given inputs; updates the scoreboard and compares outputs.
  task automatic step(input logic en, input logic b, input logic rdy, input logic clr);
    bit hit, set;
    int k;
    in_en = en; in_bit = b; out_ready = rdy; ovr_clr = clr;
    @(posedge clk);
    cyc++;
    hit = (due_q.size() > 0) && (due_q[0] == cyc);
    set = 0;
    if (hit) begin
      k = due_k.pop_front();
      void'(due_q.pop_front());
      set       = exp_valid && !rdy;
      exp_data  = model(k);
      exp_valid = 1;
    end else if (exp_valid && rdy) begin
      exp_valid = 0;
    end
    if (set)      exp_ovr = 1;
    else if (clr) exp_ovr = 0;
    if (en) begin
      hist.push_back(b);
      if (hist.size() % DECIM == 0) begin
        due_q.push_back(cyc + 3);
        due_k.push_back(int'(hist.size()) / DECIM);
      end
    end
    #1;
    checks++;
    if (out_valid !== exp_valid) begin
      errors++;
      $display("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, exp_valid);
    end
    checks++;
    if (overrun !== exp_ovr) begin
      errors++;
      $display("FAIL overrun cyc=%0d got=%b exp=%b", cyc, overrun, exp_ovr);
    end
    if (exp_valid) begin
      checks++;
      if (out_data !== exp_data) begin
        errors++;
        $display("FAIL out_data cyc=%0d got=%h exp=%h", cyc, out_data, exp_data);
      end
    end
    if (hit) begin
      samples.push_back(out_data);
      vcyc.push_back(cyc);
    end
  endtask

  task automatic do_reset();
    in_en = 0; in_bit = 0; out_ready = 1; ovr_clr = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    clear_model();
  endtask

  task automatic test_reset();
    rst = 1;
    #12;
    checks++;
    if (out_valid !== 1'b0 || overrun !== 1'b0 || out_data !== 16'h0) begin
      errors++;
      $display("FAIL reset_state got=%b/%b/%h exp=0/0/0000", out_valid, overrun, out_data);
    end
    do_reset();
  endtask

  task automatic test_all_ones();
    do_reset();
    repeat (5 * DECIM + 4) step(1, 1, 1, 0);
    checks++;
    if (samples.size() != 5) begin
      errors++;
      $display("FAIL ones_count got=%0d exp=5", samples.size());
    end
    for (int i = 2; i < int'(samples.size()); i++) begin
      checks++;
      if (samples[i] !== 16'hFFFF) begin
        errors++;
        $display("FAIL ones_value idx=%0d got=%h exp=ffff", i, samples[i]);
      end
    end
    for (int i = 1; i < int'(vcyc.size()); i++) begin
      checks++;
      if (vcyc[i] - vcyc[i-1] != DECIM) begin
        errors++;
        $display("FAIL ones_cadence idx=%0d got=%0d exp=%0d", i, vcyc[i] - vcyc[i-1], DECIM);
      end
    end
  endtask

  task automatic test_all_zeros();
    do_reset();
    repeat (4 * DECIM + 4) step(1, 0, 1, 0);
    for (int i = 0; i < int'(samples.size()); i++) begin
      checks++;
      if (samples[i] !== 16'h0000) begin
        errors++;
        $display("FAIL zeros_value idx=%0d got=%h exp=0000", i, samples[i]);
      end
    end
    checks++;
    if (samples.size() != 4 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL zeros_count_ovr got=%0d/%b exp=4/0", samples.size(), overrun);
    end
  endtask

  task automatic test_alternating();
    do_reset();
    for (int i = 0; i < 5 * DECIM + 4; i++) step(1, (i % 2) == 0, 1, 0);
    for (int i = 2; i < 5; i++) begin
      checks++;
      if (i >= int'(samples.size()) || samples[i] !== 16'h8000) begin
        errors++;
        $display("FAIL alt_value idx=%0d got=%h exp=8000", i, (i < int'(samples.size())) ? samples[i] : 16'hxxxx);
      end
    end
  endtask

  task automatic test_loopback();
    logic [15:0] acc = '0;
    logic [16:0] s;
    do_reset();
    for (int i = 0; i < 6 * DECIM + 4; i++) begin
      s   = {1'b0, acc} + 17'h04000;
      acc = s[15:0];
      step(1, s[16], 1, 0);
    end
    for (int i = 2; i < 6; i++) begin
      checks++;
      if (i >= int'(samples.size()) || samples[i] < 16'h3FF0 || samples[i] > 16'h4010) begin
        errors++;
        $display("FAIL loopback idx=%0d got=%h exp=4000+-10", i, (i < int'(samples.size())) ? samples[i] : 16'hxxxx);
      end
    end
  endtask

  task automatic test_random();
    int p;
    do_reset();
    for (int w = 0; w < 3; w++) begin
      p = $urandom_range(0, 100);
      for (int i = 0; i < 3 * DECIM; i++)
        step($urandom_range(0, 3) != 0, $urandom_range(0, 99) < p,
             $urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0);
    end
    repeat (5) step(0, 0, 1, 0);
  endtask

  task automatic test_backpressure();
    int base, guard;
    logic [15:0] held;
    do_reset();
    repeat (3 * DECIM + 4) step(1, $urandom_range(0, 1), 1, 0);
    base = samples.size();
    guard = 0;
    while (samples.size() < base + 1 && guard < 200) begin
      step(1, $urandom_range(0, 1), 0, 0); guard++;
    end
    held = out_data;
    while (samples.size() < base + 2 && guard < 400) begin
      step(1, $urandom_range(0, 1), 0, 0); guard++;
      if (samples.size() == base + 1) begin
        checks++;
        if (out_data !== held || out_valid !== 1'b1) begin
          errors++;
          $display("FAIL bp_hold got=%h/%b exp=%h/1", out_data, out_valid, held);
        end
      end
    end
    checks++;
    if (guard >= 400 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL bp_overrun got=%b exp=1 guard=%0d", overrun, guard);
    end
    step(1, 0, 0, 1);
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL bp_clear got=%b exp=0", overrun);
    end
    guard = 0;
    while (!(due_q.size() > 0 && due_q[0] == cyc + 1) && guard < 200) begin
      step(1, $urandom_range(0, 1), 0, 0); guard++;
    end
    step(1, 0, 1, 0);
    checks++;
    if (guard >= 200 || out_valid !== 1'b1 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL bp_accept_new got=%b/%b exp=1/0 guard=%0d", out_valid, overrun, guard);
    end
    repeat (3) step(0, 0, 1, 0);
  endtask

  task automatic test_reset_mid();
    int t0, guard;
    do_reset();
    repeat (2 * DECIM) step(1, 1, 1, 0);
    guard = 0;
    while (!(hist.size() % DECIM == 30 && exp_valid) && guard < 200) begin
      step(1, 1, 0, 0); guard++;
    end
    checks++;
    if (guard >= 200 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_setup got=%b exp=1 guard=%0d", out_valid, guard);
    end
    #1 rst = 1;
    #2;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'h0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL mid_async got=%b/%h/%b exp=0/0000/0", out_valid, out_data, overrun);
    end
    #2 rst = 0;
    clear_model();
    t0 = cyc;
    guard = 0;
    while (samples.size() < 1 && guard < 200) begin
      step(1, 1, 1, 0); guard++;
    end
    checks++;
    if (vcyc.size() < 1 || vcyc[0] - t0 != DECIM + 3) begin
      errors++;
      $display("FAIL mid_latency got=%0d exp=%0d", (vcyc.size() > 0) ? vcyc[0] - t0 : -1, DECIM + 3);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_all_ones();
    test_all_zeros();
    test_alternating();
    test_loopback();
    test_random();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
